// File: rtl/fetch_stage_ctrl_pkg.sv
// Shared definitions for the fetch stage: instruction encoding constants and watchdog states.
package fetch_stage_ctrl_pkg;

    localparam int unsigned PKG_INST_W = 19;
    localparam logic [PKG_INST_W-1:0] NOP = '0;

    // Opcode field of the 19-bit instruction word
    localparam int unsigned OPCODE_MSB = 18;
    localparam int unsigned OPCODE_LSB = 15;

    typedef logic [1:0] wd_state_t;
    localparam wd_state_t WD_RUN     = 2'd0;
    localparam wd_state_t WD_STALL   = 2'd1;
    localparam wd_state_t WD_TIMEOUT = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Event counter that saturates at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Fetch stage: PC register, IF/ID pipeline register, stall/flush statistics and stall watchdog.
module fetch_stage_ctrl
    import fetch_stage_ctrl_pkg::*;
#(
    parameter int unsigned PC_W      = 12,
    parameter int unsigned RESET_PC  = 0,
    parameter int unsigned INST_W    = PKG_INST_W,
    parameter int unsigned MAX_STALL = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_data,
    input  logic              pc_writebar,
    input  logic              IF_ID_loadbar,
    input  logic              IF_ID_flush,
    input  logic [PC_W-1:0]   redirect_target,
    output logic [INST_W-1:0] IF_ID_instruction,
    output logic [PC_W-1:0]   IF_ID_pc_plus1,
    output logic              IF_ID_valid,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count,
    output logic              stall_timeout
);

    localparam int unsigned RL_W = $clog2(MAX_STALL + 1);

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus1_c;
    logic            stall_cycle_c;

    wd_state_t       wd_state;
    wd_state_t       wd_state_next_c;
    logic [RL_W-1:0] run_len;
    logic [RL_W-1:0] run_len_next_c;

    assign imem_addr     = pc;
    assign pc_plus1_c    = pc + PC_W'(1);
    // A flush cycle never counts as a stall, even with pc_writebar high
    assign stall_cycle_c = pc_writebar & ~IF_ID_flush;

    // PC and IF/ID register: flush beats hold beats advance
    always_ff @(posedge clk) begin
        if (reset) begin
            pc                <= PC_W'(RESET_PC);
            IF_ID_instruction <= INST_W'(NOP);
            IF_ID_pc_plus1    <= '0;
            IF_ID_valid       <= 1'b0;
        end else if (IF_ID_flush) begin
            pc                <= redirect_target;
            IF_ID_instruction <= INST_W'(NOP);
            IF_ID_pc_plus1    <= '0;
            IF_ID_valid       <= 1'b0;
        end else begin
            if (!pc_writebar) begin
                pc <= pc_plus1_c;
            end
            if (!IF_ID_loadbar) begin
                IF_ID_instruction <= imem_data;
                IF_ID_pc_plus1    <= pc_plus1_c;
                IF_ID_valid       <= 1'b1;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_cycle_c),
        .count (stall_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (IF_ID_flush),
        .count (flush_count)
    );

    // Watchdog state register
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_state      <= WD_RUN;
            run_len       <= '0;
            stall_timeout <= 1'b0;
        end else begin
            wd_state      <= wd_state_next_c;
            run_len       <= run_len_next_c;
            stall_timeout <= (wd_state_next_c == WD_TIMEOUT);
        end
    end

    // Watchdog next state: counts consecutive stall cycles, TIMEOUT is sticky until reset
    always_comb begin
        wd_state_next_c = wd_state;
        run_len_next_c  = run_len;
        case (wd_state)
            WD_RUN: begin
                if (stall_cycle_c) begin
                    run_len_next_c  = RL_W'(1);
                    wd_state_next_c = (MAX_STALL <= 1) ? WD_TIMEOUT : WD_STALL;
                end
            end
            WD_STALL: begin
                if (stall_cycle_c) begin
                    run_len_next_c = run_len + RL_W'(1);
                    if ((run_len + RL_W'(1)) == RL_W'(MAX_STALL)) begin
                        wd_state_next_c = WD_TIMEOUT;
                    end
                end else begin
                    run_len_next_c  = '0;
                    wd_state_next_c = WD_RUN;
                end
            end
            WD_TIMEOUT: begin
                wd_state_next_c = WD_TIMEOUT;
            end
            default: begin
                wd_state_next_c = WD_RUN;
                run_len_next_c  = '0;
            end
        endcase
    end

endmodule
